// File: rtl/mem_pkg.sv
// Shared memory-access encodings and the load-extend helper used by the arbiter and the LSU.
package mem_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [2:0] RD_NONE = 3'b000;
   localparam logic [2:0] RD_LB   = 3'b001;
   localparam logic [2:0] RD_LBU  = 3'b010;
   localparam logic [2:0] RD_LH   = 3'b011;
   localparam logic [2:0] RD_LHU  = 3'b100;
   localparam logic [2:0] RD_LW   = 3'b101;

   localparam logic [1:0] WR_NONE = 2'b00;
   localparam logic [1:0] WR_SB   = 2'b01;
   localparam logic [1:0] WR_SH   = 2'b10;
   localparam logic [1:0] WR_SW   = 2'b11;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } resp_owner_e;

   function automatic logic rd_is_load(input logic [2:0] rd);
      return (rd >= RD_LB) && (rd <= RD_LW);
   endfunction

   // Alignment check; the store size wins when both controls are set (that case errors anyway).
   function automatic logic is_misaligned(input logic [2:0] rd, input logic [1:0] wr,
                                          input logic [1:0] lane);
      logic half, word;
      half = (wr == WR_SH) || (wr == WR_NONE && (rd == RD_LH || rd == RD_LHU));
      word = (wr == WR_SW) || (wr == WR_NONE && rd == RD_LW);
      return (half && lane[0]) || (word && (lane != 2'b00));
   endfunction

   function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] rd, input logic [1:0] lane,
                                                     input logic [DATA_W-1:0] word);
      logic [7:0]        b;
      logic [15:0]       h;
      logic [DATA_W-1:0] res;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (rd)
         RD_LB:   res = {{24{b[7]}}, b};
         RD_LBU:  res = {24'd0, b};
         RD_LH:   res = {{16{h[15]}}, h};
         RD_LHU:  res = {16'd0, h};
         RD_LW:   res = word;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store write enables and lane replication, plus load lane select and extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]        wr_ctrl_i,
   input  logic [1:0]        st_lane_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic [2:0]        rd_ctrl_i,
   input  logic [1:0]        ld_lane_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [3:0]        we_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] rdata_o
);

   always_comb begin
      we_o    = 4'b0000;
      wdata_o = '0;
      case (wr_ctrl_i)
         WR_SB: begin
            we_o    = 4'b0001 << st_lane_i;
            wdata_o = {4{din_i[7:0]}};
         end
         WR_SH: begin
            we_o    = 4'b0011 << {st_lane_i[1], 1'b0};
            wdata_o = {2{din_i[15:0]}};
         end
         WR_SW: begin
            we_o    = 4'b1111;
            wdata_o = din_i;
         end
         default: ;
      endcase
   end

   assign rdata_o = load_extend(rd_ctrl_i, ld_lane_i, rdata_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the load/store unit,
// with data priority, an anti-starvation counter for fetch, and a one-cycle response path.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned MEM_BYTES  = 16384,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              dm_req,
   input  logic [2:0]        dm_rd_ctrl,
   input  logic [1:0]        dm_wr_ctrl,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_din,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_dout,
   output logic              dm_err,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   resp_owner_e      owner_q, owner_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             err_q, err_d;
   logic [1:0]       lane_q, lane_d;
   logic [2:0]       rd_ctrl_q, rd_ctrl_d;

   logic        if_win, if_bad, dm_is_rd, dm_is_wr, dm_bad, dm_access;
   logic [3:0]  st_we;
   logic [31:0] st_wdata, ld_data;

   // Request qualification; bad requests are still granted but never reach memory.
   always_comb begin
      dm_is_rd  = rd_is_load(dm_rd_ctrl);
      dm_is_wr  = (dm_wr_ctrl != WR_NONE);
      dm_access = dm_is_rd || dm_is_wr;
      if_bad    = (if_addr[1:0] != 2'b00) || (if_addr >= ADDR_W'(MEM_BYTES));
      dm_bad    = ((dm_rd_ctrl != RD_NONE) && dm_is_wr)
                  || is_misaligned(dm_rd_ctrl, dm_wr_ctrl, dm_addr[1:0])
                  || (dm_access && (dm_addr >= ADDR_W'(MEM_BYTES)));
   end

   // Grants are combinational and forced low while reset is asserted.
   always_comb begin
      if_win = if_req && (!dm_req || (starve_q == CNT_W'(STARVE_MAX)));
      if_gnt = rst_n && if_win;
      dm_gnt = rst_n && dm_req && !if_win;
   end

   mem_lane_align u_lane (
      .wr_ctrl_i (dm_wr_ctrl),
      .st_lane_i (dm_addr[1:0]),
      .din_i     (dm_din),
      .rd_ctrl_i (rd_ctrl_q),
      .ld_lane_i (lane_q),
      .rdata_i   (mem_rdata),
      .we_o      (st_we),
      .wdata_o   (st_wdata),
      .rdata_o   (ld_data)
   );

   always_comb begin
      mem_en    = (if_gnt && !if_bad) || (dm_gnt && !dm_bad && dm_access);
      mem_we    = (dm_gnt && !dm_bad) ? st_we : 4'b0000;
      mem_wdata = (mem_we != 4'b0000) ? st_wdata : 32'd0;
      mem_addr  = '0;
      if (mem_en) begin
         mem_addr = if_gnt ? {if_addr[ADDR_W-1:2], 2'b00} : {dm_addr[ADDR_W-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q   <= OWN_NONE;
         starve_q  <= '0;
         err_q     <= 1'b0;
         lane_q    <= 2'b00;
         rd_ctrl_q <= RD_NONE;
      end else begin
         owner_q   <= owner_d;
         starve_q  <= starve_d;
         err_q     <= err_d;
         lane_q    <= lane_d;
         rd_ctrl_q <= rd_ctrl_d;
      end
   end

   // Next response owner and starvation count.
   always_comb begin
      owner_d   = OWN_NONE;
      starve_d  = starve_q;
      err_d     = 1'b0;
      lane_d    = 2'b00;
      rd_ctrl_d = RD_NONE;
      if (!if_req || if_gnt) begin
         starve_d = '0;
      end else if (dm_gnt && (starve_q != CNT_W'(STARVE_MAX))) begin
         starve_d = starve_q + CNT_W'(1);
      end
      if (if_gnt) begin
         owner_d = OWN_IF;
         err_d   = if_bad;
      end else if (dm_gnt) begin
         owner_d   = OWN_DM;
         err_d     = dm_bad;
         lane_d    = dm_addr[1:0];
         rd_ctrl_d = (dm_is_rd && !dm_bad) ? dm_rd_ctrl : RD_NONE;
      end
   end

   // Responses: data is zeroed on error and for stores / no-ops.
   always_comb begin
      if_rvalid = (owner_q == OWN_IF);
      if_err    = if_rvalid && err_q;
      if_rdata  = (if_rvalid && !err_q) ? mem_rdata : 32'd0;
      dm_rvalid = (owner_q == OWN_DM);
      dm_err    = dm_rvalid && err_q;
      dm_dout   = (dm_rvalid && !err_q) ? ld_data : 32'd0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-level reference memory model checked every cycle, plus directed literals.
module tb_mem_port_arbiter;

   localparam int MEM_BYTES  = 16384;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_gnt, if_rvalid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_gnt, dm_rvalid, dm_err;
   logic [2:0]  dm_rd_ctrl;
   logic [1:0]  dm_wr_ctrl;
   logic [31:0] dm_addr, dm_din, dm_dout;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] stub_mem [0:MEM_BYTES-1];
   logic [7:0] ref_mem  [0:MEM_BYTES-1];

   int          m_starve;
   int          pend_owner;
   logic        pend_err;
   logic [31:0] pend_data;

   logic        c_got, c_en, c_rv, c_err;
   logic [3:0]  c_we;
   logic [31:0] c_wd, c_addr, c_data;
   int          seq [0:9];

   mem_port_arbiter #(.ADDR_W(32), .MEM_BYTES(MEM_BYTES), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .dm_req(dm_req), .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl), .dm_addr(dm_addr),
      .dm_din(dm_din), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_dout(dm_dout), .dm_err(dm_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory array stub: registered read, byte-lane writes.
   always @(posedge clk) begin : stub
      int a;
      if (mem_en) begin
         a = int'(mem_addr[13:0]);
         for (int j = 0; j < 4; j++)
            if (mem_we[j]) stub_mem[a + j] <= mem_wdata[8*j +: 8];
         mem_rdata <= {stub_mem[a + 3], stub_mem[a + 2], stub_mem[a + 1], stub_mem[a]};
      end
   end

   // Reference model: byte-addressed memory, priority rule and response queue of depth one.
   always @(negedge clk) begin : model
      logic        e_if, e_dm, if_bad, dm_bad, e_en;
      logic [3:0]  e_we;
      logic [31:0] e_wd, e_addr, val;
      int          sz, off, a;
      if (!rst_n) begin
         chk("rst_ctrl", 32'({if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err, mem_en, mem_we}), 32'd0);
         chk("rst_rdata", if_rdata | dm_dout, 32'd0);
         chk("rst_mem_bus", mem_addr | mem_wdata, 32'd0);
         m_starve   = 0;
         pend_owner = 0;
      end else begin
         chk("if_rvalid", 32'(if_rvalid), 32'(pend_owner == 1));
         chk("dm_rvalid", 32'(dm_rvalid), 32'(pend_owner == 2));
         if (pend_owner == 1) begin
            chk("if_err", 32'(if_err), 32'(pend_err));
            chk("if_rdata", if_rdata, pend_data);
         end
         if (pend_owner == 2) begin
            chk("dm_err", 32'(dm_err), 32'(pend_err));
            chk("dm_dout", dm_dout, pend_data);
         end

         e_if = if_req && (!dm_req || m_starve == STARVE_MAX);
         e_dm = dm_req && !e_if;
         chk("grants", 32'({if_gnt, dm_gnt}), 32'({e_if, e_dm}));

         if (dm_wr_ctrl == 2'b01)      sz = 1;
         else if (dm_wr_ctrl == 2'b10) sz = 2;
         else if (dm_wr_ctrl == 2'b11) sz = 4;
         else if (dm_rd_ctrl == 3'b001 || dm_rd_ctrl == 3'b010) sz = 1;
         else if (dm_rd_ctrl == 3'b011 || dm_rd_ctrl == 3'b100) sz = 2;
         else if (dm_rd_ctrl == 3'b101) sz = 4;
         else sz = 0;
         off    = int'(dm_addr[1:0]);
         if_bad = (if_addr[1:0] != 2'b00) || (if_addr >= 32'(MEM_BYTES));
         dm_bad = (dm_rd_ctrl != 3'b000 && dm_wr_ctrl != 2'b00)
                  || (sz != 0 && ((off % sz) != 0 || dm_addr >= 32'(MEM_BYTES)));
         e_en   = (e_if && !if_bad) || (e_dm && !dm_bad && sz != 0);
         e_we   = 4'b0000;
         e_wd   = 32'd0;
         if (e_dm && !dm_bad && dm_wr_ctrl != 2'b00) begin
            for (int j = 0; j < 4; j++) begin
               if (j >= off && j < off + sz) e_we[j] = 1'b1;
               e_wd[8*j +: 8] = dm_din[8*(j % sz) +: 8];
            end
         end
         chk("mem_en", 32'(mem_en), 32'(e_en));
         chk("mem_we", 32'(mem_we), 32'(e_we));
         if (e_en) begin
            e_addr = (e_if ? if_addr : dm_addr) & 32'hFFFF_FFFC;
            chk("mem_addr", mem_addr, e_addr);
         end
         if (e_we != 4'b0000) chk("mem_wdata", mem_wdata, e_wd);

         pend_owner = 0;
         pend_err   = 1'b0;
         pend_data  = 32'd0;
         if (e_if) begin
            pend_owner = 1;
            pend_err   = if_bad;
            if (!if_bad) begin
               a = int'(if_addr);
               pend_data = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
            end
         end else if (e_dm) begin
            pend_owner = 2;
            pend_err   = dm_bad;
            if (!dm_bad && sz != 0) begin
               a = int'(dm_addr);
               if (dm_wr_ctrl != 2'b00) begin
                  for (int k = 0; k < sz; k++) ref_mem[a + k] = dm_din[8*k +: 8];
               end else begin
                  val = 32'd0;
                  for (int k = 0; k < sz; k++) val[8*k +: 8] = ref_mem[a + k];
                  if ((dm_rd_ctrl == 3'b001 || dm_rd_ctrl == 3'b011) && val[8*sz - 1])
                     for (int k = sz; k < 4; k++) val[8*k +: 8] = 8'hFF;
                  pend_data = val;
               end
            end
         end

         if (!if_req || e_if)                          m_starve = 0;
         else if (e_dm && m_starve < STARVE_MAX)       m_starve++;
      end
   end

   task automatic dm_op(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                        input logic [31:0] din);
      int n;
      @(posedge clk); #1;
      dm_req = 1'b1; dm_rd_ctrl = rd; dm_wr_ctrl = wr; dm_addr = addr; dm_din = din;
      c_got = 1'b0; n = 0;
      while (!c_got && n < 20) begin
         @(negedge clk);
         if (dm_gnt) begin
            c_got = 1'b1; c_we = mem_we; c_en = mem_en; c_wd = mem_wdata; c_addr = mem_addr;
         end
         @(posedge clk); #1;
         n++;
      end
      dm_req = 1'b0; dm_rd_ctrl = 3'b000; dm_wr_ctrl = 2'b00;
      if (!c_got) chk("dm_gnt_wait", 32'd0, 32'd1);
      @(negedge clk);
      c_rv = dm_rvalid; c_data = dm_dout; c_err = dm_err;
   endtask

   task automatic if_op(input logic [31:0] addr);
      int n;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = addr;
      c_got = 1'b0; n = 0;
      while (!c_got && n < 20) begin
         @(negedge clk);
         if (if_gnt) begin
            c_got = 1'b1; c_en = mem_en; c_addr = mem_addr;
         end
         @(posedge clk); #1;
         n++;
      end
      if_req = 1'b0;
      if (!c_got) chk("if_gnt_wait", 32'd0, 32'd1);
      @(negedge clk);
      c_rv = if_rvalid; c_data = if_rdata; c_err = if_err;
   endtask

   initial begin
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = 32'd0;
      dm_req = 1'b0; dm_rd_ctrl = 3'b000; dm_wr_ctrl = 2'b00; dm_addr = 32'd0; dm_din = 32'd0;
      mem_rdata = 32'd0;
      for (int i = 0; i < MEM_BYTES; i++) begin
         stub_mem[i] = 8'(i * 7 + 3);
         ref_mem[i]  = 8'(i * 7 + 3);
      end
      {stub_mem[19], stub_mem[18], stub_mem[17], stub_mem[16]} = 32'h00A0_0093;
      {ref_mem[19],  ref_mem[18],  ref_mem[17],  ref_mem[16]}  = 32'h00A0_0093;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset asserted while a fetch response is in flight.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h10;
      @(posedge clk); #1;
      if_req = 1'b0;
      #1 chk("rst_pre_rvalid", 32'(if_rvalid), 32'd1);
      rst_n = 1'b0;
      #1 chk("rst_async_rvalid", 32'(if_rvalid), 32'd0);
      if_req = 1'b1; dm_req = 1'b1; dm_rd_ctrl = 3'b101; dm_addr = 32'h0;
      #1 chk("rst_gnt_blocked", 32'({if_gnt, dm_gnt, mem_en}), 32'd0);
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0; dm_rd_ctrl = 3'b000;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_no_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);

      // Single fetch.
      if_op(32'h10);
      chk("if_fetch_addr", c_addr, 32'h10);
      chk("if_fetch_rv", 32'(c_rv), 32'd1);
      chk("if_fetch_data", c_data, 32'h00A0_0093);

      // Both requesting continuously: DM x4, then IF once, repeating.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h20;
      dm_req = 1'b1; dm_rd_ctrl = 3'b101; dm_addr = 32'h24;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seq[i] = dm_gnt ? 1 : (if_gnt ? 2 : 0);
      end
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0; dm_rd_ctrl = 3'b000;
      for (int i = 0; i < 10; i++) chk("starve_pattern", 32'(seq[i]), (i % 5 == 4) ? 32'd2 : 32'd1);

      // Byte store/load.
      dm_op(3'b000, 2'b01, 32'h103, 32'h0000_00FF);
      chk("sb_we", 32'(c_we), 32'b1000);
      chk("sb_wdata", c_wd, 32'hFFFF_FFFF);
      dm_op(3'b001, 2'b00, 32'h103, 32'd0);
      chk("lb_dout", c_data, 32'hFFFF_FFFF);
      dm_op(3'b010, 2'b00, 32'h103, 32'd0);
      chk("lbu_dout", c_data, 32'h0000_00FF);

      // Half store/load.
      dm_op(3'b000, 2'b10, 32'h102, 32'h0000_8001);
      chk("sh_we", 32'(c_we), 32'b1100);
      dm_op(3'b011, 2'b00, 32'h102, 32'd0);
      chk("lh_dout", c_data, 32'hFFFF_8001);
      dm_op(3'b100, 2'b00, 32'h102, 32'd0);
      chk("lhu_dout", c_data, 32'h0000_8001);

      // Error cases.
      dm_op(3'b101, 2'b00, 32'h101, 32'd0);
      chk("lw_misal_err", 32'({c_err, c_en}), 32'b10);
      chk("lw_misal_dout", c_data, 32'd0);
      dm_op(3'b101, 2'b00, 32'h4000, 32'd0);
      chk("lw_oor_err", 32'({c_err, c_en}), 32'b10);
      dm_op(3'b101, 2'b11, 32'h200, 32'h1234_5678);
      chk("rd_wr_both_err", 32'({c_err, c_en, c_we}), 32'b100000);

      // Word round trip, no-op ack, misaligned fetch.
      dm_op(3'b000, 2'b11, 32'h200, 32'h1122_3344);
      dm_op(3'b101, 2'b00, 32'h200, 32'd0);
      chk("lw_dout", c_data, 32'h1122_3344);
      dm_op(3'b011, 2'b00, 32'h202, 32'd0);
      chk("lh_hi_dout", c_data, 32'h0000_1122);
      dm_op(3'b000, 2'b00, 32'h300, 32'd0);
      chk("noop_ack", 32'({c_rv, c_err, c_en}), 32'b100);
      if_op(32'h12);
      chk("if_misal", 32'({c_rv, c_err, c_en}), 32'b110);
      chk("if_misal_data", c_data, 32'd0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
